// File: rtl/hex_disp_pkg.sv
// rtl/hex_disp_pkg.sv - shared types, widths and active-low segment decoder for the HEX scheduler
package hex_disp_pkg;

    typedef enum logic {IDLE = 1'b0, SHOW = 1'b1} state_t;

    localparam int SEG_W = 7;
    localparam int NIB_W = 4;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

    // Bit order g..a, a cleared bit lights the segment.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/hex_display_scheduler_rr_arbiter.sv
// rtl/hex_display_scheduler_rr_arbiter.sv - combinational round-robin arbiter, search starts at ptr and wraps
module rr_arbiter #(
    parameter int N = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] gnt_idx,
    output logic          any
);

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        if (en) begin
            for (int i = 0; i < N; i++) begin
                if (!any && req[(int'(ptr) + i) % N]) begin
                    any                       = 1'b1;
                    gnt[(int'(ptr) + i) % N]  = 1'b1;
                    gnt_idx                   = PW'((int'(ptr) + i) % N);
                end
            end
        end
    end

endmodule

// File: rtl/hex_display_scheduler.sv
// rtl/hex_display_scheduler.sv - round-robin sharing of the HEX displays with a fixed dwell per grant
module hex_display_scheduler
    import hex_disp_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int DIGITS = 6,
    parameter int DWELL  = 50_000_000,
    localparam int OW = $clog2(N_REQ),
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1,
    localparam int DW = NIB_W * DIGITS
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DW-1:0]     req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic [DIGITS*SEG_W-1:0] hex,
    output logic [OW-1:0]           owner,
    output logic                    busy
);

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic [OW-1:0]   ptr;
    logic [OW-1:0]   gnt_idx;
    logic [DW-1:0]   disp_reg;
    logic            blank_reg;
    logic            arb_pt;
    logic            any;
    logic [N_REQ-1:0] gnt;

    // The last dwell cycle doubles as an arbitration point so grants run back-to-back.
    assign arb_pt = (state == IDLE) || (cnt == '0);

    rr_arbiter #(.N(N_REQ)) u_arb (
        .req     (req_valid),
        .ptr     (ptr),
        .en      (arb_pt && !reset),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (any)
    );

    assign req_ready = gnt;
    assign busy      = (state == SHOW);

    always_comb begin
        state_nxt = state;
        if (arb_pt)
            state_nxt = any ? SHOW : IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            ptr       <= '0;
            owner     <= '0;
            disp_reg  <= '0;
            blank_reg <= 1'b1;
        end else if (arb_pt && any) begin
            cnt       <= CW'(DWELL - 1);
            ptr       <= (gnt_idx == OW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            owner     <= gnt_idx;
            disp_reg  <= req_data[int'(gnt_idx)*DW +: DW];
            blank_reg <= 1'b0;
        end else if (!arb_pt) begin
            cnt <= cnt - 1'b1;
        end
    end

    for (genvar d = 0; d < DIGITS; d++) begin : g_digit
        assign hex[d*SEG_W +: SEG_W] = blank_reg ? SEG_BLANK : seg_decode(disp_reg[d*NIB_W +: NIB_W]);
    end

endmodule

// File: tb/tb_hex_display_scheduler.sv
// tb/tb_hex_display_scheduler.sv - directed bench for hex_display_scheduler (DWELL=4 and DWELL=1 instances)
module tb_hex_display_scheduler;

    localparam logic [41:0] HEX_BLANK  = {6{7'h7F}};
    localparam logic [41:0] HEX_111111 = {6{7'h79}};
    localparam logic [41:0] HEX_12AB3F = {7'h79, 7'h24, 7'h08, 7'h03, 7'h30, 7'h0E};
    localparam logic [41:0] HEX_456789 = {7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    localparam logic [41:0] HEX_FFFFFF = {6{7'h0E}};

    logic        clk = 1'b0;
    logic        reset, reset1;
    logic [3:0]  req_valid, valid1;
    logic [95:0] req_data, data1;
    logic [3:0]  req_ready, ready1;
    logic [41:0] hex, hex1;
    logic [1:0]  owner, owner1;
    logic        busy, busy1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hex_display_scheduler #(.N_REQ(4), .DIGITS(6), .DWELL(4)) u_dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .hex(hex), .owner(owner), .busy(busy)
    );

    hex_display_scheduler #(.N_REQ(4), .DIGITS(6), .DWELL(1)) u_dut1 (
        .clk(clk), .reset(reset1), .req_valid(valid1), .req_data(data1),
        .req_ready(ready1), .hex(hex1), .owner(owner1), .busy(busy1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        req_valid = 4'b1111;
        req_data  = {24'h444444, 24'h333333, 24'h222222, 24'h111111};
        for (int c = 0; c < 2; c++) begin
            tick();
            #1;
            total++;
            if (hex !== HEX_BLANK) begin bad++; $display("FAIL reset_hex: got %h want %h", hex, HEX_BLANK); end
            total++;
            if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
            total++;
            if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        end
        tick();
        reset = 1'b0;
        #1;
        total++;
        if (req_ready !== 4'b0001) begin bad++; $display("FAIL reset_first_grant: got %b want 0001", req_ready); end
        tick();
        #1;
        total++;
        if (owner !== 2'd0 || busy !== 1'b1 || hex !== HEX_111111) begin
            bad++; $display("FAIL reset_first_show: got owner=%0d busy=%b hex=%h want owner=0 busy=1 hex=%h", owner, busy, hex, HEX_111111);
        end
    endtask

    task automatic test_single();
        req_valid = 4'b0000;
        do_reset();
        req_valid = 4'b0100;
        req_data[48 +: 24] = 24'h12AB3F;
        #1;
        total++;
        if (req_ready !== 4'b0100) begin bad++; $display("FAIL single_ready: got %b want 0100", req_ready); end
        tick();
        req_valid = 4'b0000;
        for (int c = 1; c <= 4; c++) begin
            #1;
            total++;
            if (hex !== HEX_12AB3F || owner !== 2'd2 || busy !== 1'b1) begin
                bad++; $display("FAIL single_show%0d: got hex=%h owner=%0d busy=%b want hex=%h owner=2 busy=1", c, hex, owner, busy, HEX_12AB3F);
            end
            tick();
        end
        #1;
        total++;
        if (busy !== 1'b0 || hex !== HEX_12AB3F || owner !== 2'd2) begin
            bad++; $display("FAIL single_hold: got busy=%b hex=%h owner=%0d want busy=0 hex=%h owner=2", busy, hex, owner, HEX_12AB3F);
        end
    endtask

    task automatic test_rotation();
        logic [3:0] exp_rdy;
        logic [1:0] exp_own;
        req_valid = 4'b0000;
        do_reset();
        req_valid = 4'b1111;
        for (int c = 0; c <= 16; c++) begin
            if (c > 0) tick();
            #1;
            exp_rdy = (c % 4 == 0) ? 4'(1 << ((c / 4) % 4)) : 4'b0000;
            total++;
            if (req_ready !== exp_rdy) begin bad++; $display("FAIL rotation_ready c=%0d: got %b want %b", c, req_ready, exp_rdy); end
            if (c > 0) begin
                exp_own = 2'(((c - 1) / 4) % 4);
                total++;
                if (owner !== exp_own || busy !== 1'b1) begin
                    bad++; $display("FAIL rotation_owner c=%0d: got owner=%0d busy=%b want owner=%0d busy=1", c, owner, busy, exp_own);
                end
            end
        end
    endtask

    task automatic test_fairness();
        req_valid = 4'b0000;
        do_reset();
        req_valid = 4'b0001;
        #1;
        total++;
        if (req_ready !== 4'b0001) begin bad++; $display("FAIL fair_first: got %b want 0001", req_ready); end
        tick();
        req_valid = 4'b1001;
        for (int c = 1; c <= 12; c++) begin
            if (c > 1) tick();
            #1;
            if (c == 4 || c == 12) begin
                total++;
                if (req_ready !== 4'b1000) begin bad++; $display("FAIL fair_grant3 c=%0d: got %b want 1000", c, req_ready); end
            end else if (c == 8) begin
                total++;
                if (req_ready !== 4'b0001) begin bad++; $display("FAIL fair_grant0 c=%0d: got %b want 0001", c, req_ready); end
            end else begin
                total++;
                if (req_ready !== 4'b0000) begin bad++; $display("FAIL fair_idle c=%0d: got %b want 0000", c, req_ready); end
            end
        end
    endtask

    task automatic test_middwell();
        req_valid = 4'b0000;
        do_reset();
        req_valid = 4'b0010;
        req_data[24 +: 24] = 24'h456789;
        #1;
        total++;
        if (req_ready !== 4'b0010) begin bad++; $display("FAIL mid_grant: got %b want 0010", req_ready); end
        tick();
        req_data[24 +: 24] = 24'hFFFFFF;
        for (int c = 1; c <= 4; c++) begin
            if (c > 1) tick();
            #1;
            total++;
            if (hex !== HEX_456789) begin bad++; $display("FAIL mid_hex c=%0d: got %h want %h", c, hex, HEX_456789); end
            total++;
            if (req_ready !== ((c == 4) ? 4'b0010 : 4'b0000)) begin
                bad++; $display("FAIL mid_ready c=%0d: got %b want %b", c, req_ready, (c == 4) ? 4'b0010 : 4'b0000);
            end
        end
        tick();
        req_valid = 4'b0000;
        req_data[24 +: 24] = 24'h000000;
        for (int c = 5; c <= 9; c++) begin
            if (c > 5) tick();
            #1;
            total++;
            if (hex !== HEX_FFFFFF || busy !== (c <= 8)) begin
                bad++; $display("FAIL mid_regrant c=%0d: got hex=%h busy=%b want hex=%h busy=%b", c, hex, busy, HEX_FFFFFF, c <= 8);
            end
        end
    endtask

    task automatic test_reset_mid_show();
        req_valid = 4'b0000;
        do_reset();
        req_valid = 4'b0001;
        req_data[0 +: 24] = 24'h111111;
        tick();
        tick();
        reset = 1'b1;
        #1;
        total++;
        if (req_ready !== 4'b0000 || busy !== 1'b1) begin
            bad++; $display("FAIL midreset_pre: got ready=%b busy=%b want ready=0000 busy=1", req_ready, busy);
        end
        tick();
        #1;
        total++;
        if (hex !== HEX_BLANK || busy !== 1'b0 || owner !== 2'd0 || req_ready !== 4'b0000) begin
            bad++; $display("FAIL midreset_post: got hex=%h busy=%b owner=%0d ready=%b want blank, 0, 0, 0000", hex, busy, owner, req_ready);
        end
        reset = 1'b0;
        req_valid = 4'b0000;
    endtask

    task automatic test_dwell1();
        logic [3:0] exp_rdy;
        logic [1:0] exp_own;
        reset1 = 1'b1;
        valid1 = 4'b0000;
        data1  = {24'h444444, 24'h333333, 24'h222222, 24'h111111};
        tick();
        tick();
        reset1 = 1'b0;
        valid1 = 4'b0011;
        #1;
        total++;
        if (ready1 !== 4'b0001) begin bad++; $display("FAIL dwell1_first: got %b want 0001", ready1); end
        for (int c = 1; c <= 6; c++) begin
            tick();
            #1;
            exp_own = 2'((c - 1) % 2);
            exp_rdy = 4'(1 << (c % 2));
            total++;
            if (owner1 !== exp_own || ready1 !== exp_rdy || busy1 !== 1'b1) begin
                bad++; $display("FAIL dwell1 c=%0d: got owner=%0d ready=%b busy=%b want owner=%0d ready=%b busy=1", c, owner1, ready1, busy1, exp_own, exp_rdy);
            end
        end
        total++;
        if (hex1 === HEX_BLANK) begin bad++; $display("FAIL dwell1_hex: got %h want non-blank", hex1); end
    endtask

    initial begin
        reset     = 1'b1;
        reset1    = 1'b1;
        req_valid = 4'b0000;
        valid1    = 4'b0000;
        req_data  = '0;
        data1     = '0;
        test_reset();
        test_single();
        test_rotation();
        test_fairness();
        test_middwell();
        test_reset_mid_show();
        test_dwell1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
